// File: rtl/snake_coord_encoder.sv
// Snake body store and frame streamer: advances the body one cell per step and emits
// clear + one coordinate per clock + done to the LED-matrix frame decoder.
module snake_coord_encoder #(
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned INIT_LEN  = 3,
  parameter logic [7:0]  INIT_HEAD = 8'h88
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       redraw,
  input  logic [1:0] dir,
  input  logic       grow,
  output logic       clr_out,
  output logic [7:0] coord_out,
  output logic       coord_valid,
  output logic       frame_done,
  output logic       busy,
  output logic [6:0] len,
  output logic       collide
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirRight = 2'b11;

  typedef enum logic [1:0] {StIdle, StClear, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [6:0]        len_q, len_d;
  logic [1:0]        dir_q, dir_d;
  logic              collide_q, collide_d;
  logic [7:0]        seg_q [MAX_LEN];
  logic [7:0]        seg_d [MAX_LEN];

  logic              clr_q, valid_q, done_q, busy_q;
  logic [7:0]        coord_q, coord_d;

  logic [1:0]        dir_new;
  logic [3:0]        head_x, head_y;
  logic [7:0]        head_new;
  logic              hit;

  // Direction filter, next head and self-collision check for a step in this cycle.
  always_comb begin
    dir_new = dir;
    if (len_q > 7'd1 && dir == {dir_q[1], ~dir_q[0]}) begin
      dir_new = dir_q;
    end

    head_x = seg_q[0][7:4];
    head_y = seg_q[0][3:0];
    unique case (dir_new)
      DirUp:    head_y = seg_q[0][3:0] - 4'd1;
      DirDown:  head_y = seg_q[0][3:0] + 4'd1;
      DirLeft:  head_x = seg_q[0][7:4] - 4'd1;
      DirRight: head_x = seg_q[0][7:4] + 4'd1;
      default:  head_x = seg_q[0][7:4];
    endcase
    head_new = {head_x, head_y};

    // The tail cell only counts when growing, since otherwise it vacates this step.
    hit = 1'b0;
    for (int k = 0; k < int'(MAX_LEN); k++) begin
      if (seg_q[k] == head_new &&
          ((k + 2 <= int'(len_q)) || (grow && (k + 1 <= int'(len_q))))) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    dir_d     = dir_q;
    collide_d = collide_q;
    seg_d     = seg_q;

    unique case (state_q)
      StIdle: begin
        if (step) begin
          state_d = StClear;
          dir_d   = dir_new;
          if (hit) begin
            collide_d = 1'b1;
          end else begin
            seg_d[0] = head_new;
            for (int k = 1; k < int'(MAX_LEN); k++) begin
              seg_d[k] = seg_q[k-1];
            end
            if (grow && len_q < 7'(MAX_LEN)) begin
              len_d = len_q + 7'd1;
            end
          end
        end else if (redraw) begin
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = StEmit;
        idx_d   = '0;
      end
      StEmit: begin
        if (7'(idx_q) == len_q - 7'd1) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Body is stable outside IDLE, so the coordinate can be fetched one cycle ahead.
    coord_d = (state_d == StEmit) ? seg_q[idx_d] : coord_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      len_q     <= 7'(INIT_LEN);
      dir_q     <= DirRight;
      collide_q <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_q[i] <= {INIT_HEAD[7:4] - 4'(i), INIT_HEAD[3:0]};
      end
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      coord_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      collide_q <= collide_d;
      seg_q     <= seg_d;
      clr_q     <= (state_d == StClear);
      valid_q   <= (state_d == StEmit);
      done_q    <= (state_d == StDone);
      busy_q    <= (state_d != StIdle);
      coord_q   <= coord_d;
    end
  end

  assign clr_out     = clr_q;
  assign coord_out   = coord_q;
  assign coord_valid = valid_q;
  assign frame_done  = done_q;
  assign busy        = busy_q;
  assign len         = len_q;
  assign collide     = collide_q;

endmodule

// File: tb/tb_snake_coord_encoder.sv
// Scoreboard bench for snake_coord_encoder: a behavioural snake model queues the expected
// clear/coordinate/done events of each frame and a monitor pops them as the DUT emits.
module tb_snake_coord_encoder;

  localparam int MaxLen = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step, redraw, grow;
  logic [1:0] dir;
  logic       clr_out, coord_valid, frame_done, busy, collide;
  logic [7:0] coord_out;
  logic [6:0] len;

  snake_coord_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .redraw     (redraw),
    .dir        (dir),
    .grow       (grow),
    .clr_out    (clr_out),
    .coord_out  (coord_out),
    .coord_valid(coord_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .len        (len),
    .collide    (collide)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;  // 0 clear, 1 coordinate, 2 done
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         asserts = 0;
  int         errors  = 0;
  int         frames_seen = 0;
  int         frames_exp  = 0;
  logic [7:0] last_coord = 8'h00;
  logic [7:0] head_seen  = 8'h00;
  bit         want_head  = 1'b0;

  logic [7:0] m_seg [64];
  int         m_len;
  logic [1:0] m_dir;
  bit         m_col;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_seg[i] = {4'h8 - 4'(i), 4'h8};
    m_len = 3;
    m_dir = 2'b11;
    m_col = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] d, input bit g);
    logic [1:0] nd;
    logic [3:0] x, y;
    logic [7:0] nh;
    bit         hit;
    nd = d;
    if (m_len > 1 && ((m_dir == 2'd0 && d == 2'd1) || (m_dir == 2'd1 && d == 2'd0) ||
                      (m_dir == 2'd2 && d == 2'd3) || (m_dir == 2'd3 && d == 2'd2))) begin
      nd = m_dir;
    end
    x = m_seg[0][7:4];
    y = m_seg[0][3:0];
    case (nd)
      2'd0: y = y - 4'd1;
      2'd1: y = y + 4'd1;
      2'd2: x = x - 4'd1;
      default: x = x + 4'd1;
    endcase
    nh  = {x, y};
    hit = 1'b0;
    for (int k = 0; k < m_len - 1 + (g ? 1 : 0); k++) begin
      if (m_seg[k] == nh) hit = 1'b1;
    end
    m_dir = nd;
    if (hit) begin
      m_col = 1'b1;
    end else begin
      for (int k = MaxLen - 1; k > 0; k--) m_seg[k] = m_seg[k-1];
      m_seg[0] = nh;
      if (g && m_len < MaxLen) m_len++;
    end
  endtask

  task automatic push_frame();
    exp_q.push_back('{kind: 2'd0, val: 8'h00});
    for (int i = 0; i < m_len; i++) exp_q.push_back('{kind: 2'd1, val: m_seg[i]});
    exp_q.push_back('{kind: 2'd2, val: 8'h00});
  endtask

  always @(negedge clk) begin
    if (rst_n && (clr_out || coord_valid || frame_done)) begin
      ev_t        e;
      logic [1:0] kind;
      kind = frame_done ? 2'd2 : (coord_valid ? 2'd1 : 2'd0);
      check("ev_onehot", 32'(clr_out) + 32'(coord_valid) + 32'(frame_done), 1);
      if (exp_q.size() == 0) begin
        check("ev_unexpected", {30'd0, kind}, 32'd3);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", {30'd0, kind}, {30'd0, e.kind});
        if (e.kind == 2'd1) check("coord", {24'd0, coord_out}, {24'd0, e.val});
      end
      if (clr_out) want_head = 1'b1;
      if (coord_valid) begin
        if (want_head) head_seen = coord_out;
        want_head  = 1'b0;
        last_coord = coord_out;
      end
      if (frame_done) begin
        check("coord_hold", {24'd0, coord_out}, {24'd0, last_coord});
        frames_seen++;
      end
    end
  end

  // Drive one strobe at a negedge, then follow the frame to its done pulse.
  task automatic run_frame(input bit s, input bit r, input logic [1:0] d, input bit g,
                           input bit poke);
    int n;
    @(negedge clk);
    step = s; redraw = r; dir = d; grow = g;
    if (s) model_step(d, g);
    push_frame();
    frames_exp++;
    @(negedge clk);
    step = 1'b0; redraw = 1'b0; grow = 1'b0;
    check("len", {25'd0, len}, 32'(m_len));
    check("busy_hi", {31'd0, busy}, 1);
    n = 1;
    while (!frame_done && n < 200) begin
      if (poke && n == 3) begin
        step = 1'b1; dir = 2'b10; grow = 1'b1;
      end else begin
        step = 1'b0; grow = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("frame_period", 32'(n), 32'(m_len + 2));
    @(negedge clk);
    check("busy_lo", {31'd0, busy}, 0);
    check("collide", {31'd0, collide}, {31'd0, m_col});
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; step = 1'b0; redraw = 1'b0; grow = 1'b0; dir = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_len", {25'd0, len}, 3);
    check("rst_flags", {27'd0, clr_out, coord_valid, frame_done, busy, collide}, 0);
    check("rst_coord", {24'd0, coord_out}, 0);

    run_frame(0, 1, 2'b00, 0, 0);
    check("redraw_head", {24'd0, head_seen}, 32'h88);
    run_frame(1, 0, 2'b11, 0, 0);
    check("right_head", {24'd0, head_seen}, 32'h98);
    run_frame(1, 0, 2'b01, 0, 0);
    check("down_head", {24'd0, head_seen}, 32'h99);
    run_frame(1, 0, 2'b11, 0, 0);
    run_frame(1, 0, 2'b10, 0, 0);
    check("reverse_head", {24'd0, head_seen}, 32'hB9);
    check("reverse_collide", {31'd0, collide}, 0);

    for (int i = 0; i < 5; i++) run_frame(1, 0, 2'b11, 0, 0);
    check("wrap_x", {24'd0, head_seen}, 32'h09);
    for (int i = 0; i < 10; i++) run_frame(1, 0, 2'b00, 0, 0);
    check("wrap_y", {24'd0, head_seen}, 32'h0F);

    run_frame(1, 0, 2'b11, 1, 1);
    check("grow_len4", {25'd0, len}, 4);
    check("frames_after_poke", 32'(frames_seen), 32'(frames_exp));
    run_frame(1, 0, 2'b11, 1, 0);
    check("grow_len5", {25'd0, len}, 5);
    run_frame(1, 0, 2'b01, 0, 0);
    run_frame(1, 0, 2'b10, 0, 0);
    run_frame(1, 0, 2'b00, 0, 0);
    check("collide_set", {31'd0, collide}, 1);
    check("collide_head", {24'd0, head_seen}, 32'h10);
    check("collide_len", {25'd0, len}, 5);

    @(negedge clk);
    redraw = 1'b1;
    push_frame();
    @(negedge clk);
    redraw = 1'b0;
    n = 0;
    while (!coord_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_emit", {31'd0, coord_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_flags", {27'd0, clr_out, coord_valid, frame_done, busy, collide}, 0);
    check("midrst_coord", {24'd0, coord_out}, 0);
    check("midrst_len", {25'd0, len}, 3);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 1, 2'b00, 0, 0);
    check("post_rst_head", {24'd0, head_seen}, 32'h88);
    check("frame_count", 32'(frames_seen), 32'(frames_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
